// File: rtl/ieee_src_handshake.sv
// IEEE-488 source handshake: places one byte on the bus with DAV/EOI/ATN and
// paces it against the listeners' wired-AND NRFD/NDAC lines.
module ieee_src_handshake #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       atn_release,
  input  logic       bus_i_nrfd,
  input  logic       bus_i_ndac,
  output logic       bus_o_dav,
  output logic       bus_o_eoi,
  output logic       bus_o_atn,
  output logic [7:0] bus_o_data,
  output logic       busy,
  output logic       done,
  output logic       err_nodev,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CHECK,
    WAIT_RFD,
    WAIT_DAC,
    RELEASE
  } state_t;

  // One counter serves both the settle interval and the wait-state timeout.
  localparam int            CW           = 24;
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            eoi_q, eoi_d;
  logic            flag_q, flag_d;
  logic            nodev_d, timeout_d, drive_d;
  logic            accept;
  logic [1:0]      nrfd_sync, ndac_sync;
  logic            nrfd_s, ndac_s;

  // Bus lines are asynchronous to clk_sys; idle (released) level is 1.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      nrfd_sync <= 2'b11;
      ndac_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make both flops sample old values on
      // the same edge; blocking here would collapse the chain to one stage.
      nrfd_sync <= {nrfd_sync[0], bus_i_nrfd};
      ndac_sync <= {ndac_sync[0], bus_i_ndac};
    end
  end

  assign nrfd_s = nrfd_sync[1];
  assign ndac_s = ndac_sync[1];

  assign accept    = tx_valid & tx_ready & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign bus_o_atn = ~flag_q;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    data_d    = data_q;
    eoi_d     = eoi_q;
    flag_d    = flag_q;
    nodev_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          data_d  = tx_data;
          eoi_d   = tx_eoi & ~tx_atn;
          flag_d  = tx_atn;
          state_d = SETUP;
        end else if (atn_release) begin
          flag_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        cnt_d = '0;
        if (nrfd_s && ndac_s) begin
          nodev_d = 1'b1;
          flag_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_RFD;
        end
      end
      WAIT_RFD: begin
        // The awaited condition is tested first so it wins a same-cycle tie.
        if (nrfd_s) begin
          cnt_d   = '0;
          state_d = WAIT_DAC;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          flag_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      WAIT_DAC: begin
        if (ndac_s) begin
          state_d = RELEASE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          flag_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    drive_d = state_d inside {SETUP, CHECK, WAIT_RFD, WAIT_DAC};
  end

  // Bus outputs and status pulses are registered from the next state so they
  // change cleanly on the same edge as the state they belong to.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      eoi_q       <= 1'b0;
      flag_q      <= 1'b0;
      tx_ready    <= 1'b0;
      bus_o_dav   <= 1'b1;
      bus_o_eoi   <= 1'b1;
      bus_o_data  <= 8'hFF;
      done        <= 1'b0;
      err_nodev   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      eoi_q       <= eoi_d;
      flag_q      <= flag_d;
      tx_ready    <= (state_d == IDLE);
      bus_o_dav   <= (state_d != WAIT_DAC);
      bus_o_eoi   <= drive_d ? ~eoi_d : 1'b1;
      bus_o_data  <= drive_d ? ~data_d : 8'hFF;
      done        <= (state_d == RELEASE);
      err_nodev   <= nodev_d;
      err_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ieee_src_handshake.sv
// Directed bench for ieee_src_handshake with SETTLE=4, TIMEOUT=16; the bus
// listener is driven step by step with hand-computed cycle timing.
module tb_ieee_src_handshake;

  logic       clk_sys;
  logic       reset_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_atn;
  logic       tx_eoi;
  logic       atn_release;
  logic       bus_i_nrfd;
  logic       bus_i_ndac;
  logic       bus_o_dav;
  logic       bus_o_eoi;
  logic       bus_o_atn;
  logic [7:0] bus_o_data;
  logic       busy;
  logic       done;
  logic       err_nodev;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;

  int done_cnt     = 0;
  int nodev_cnt    = 0;
  int to_cnt       = 0;
  int dav_low_cnt  = 0;
  int atn_high_cnt = 0;
  int eoi_atn_cnt  = 0;

  ieee_src_handshake #(.SETTLE(4), .TIMEOUT(16)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_atn      (tx_atn),
    .tx_eoi      (tx_eoi),
    .atn_release (atn_release),
    .bus_i_nrfd  (bus_i_nrfd),
    .bus_i_ndac  (bus_i_ndac),
    .bus_o_dav   (bus_o_dav),
    .bus_o_eoi   (bus_o_eoi),
    .bus_o_atn   (bus_o_atn),
    .bus_o_data  (bus_o_data),
    .busy        (busy),
    .done        (done),
    .err_nodev   (err_nodev),
    .err_timeout (err_timeout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Event tallies over whole cycles, used for pulse-count and "never" checks.
  always @(posedge clk_sys) begin
    if (done)                     done_cnt     <= done_cnt + 1;
    if (err_nodev)                nodev_cnt    <= nodev_cnt + 1;
    if (err_timeout)              to_cnt       <= to_cnt + 1;
    if (!bus_o_dav)               dav_low_cnt  <= dav_low_cnt + 1;
    if (bus_o_atn)                atn_high_cnt <= atn_high_cnt + 1;
    if (!bus_o_eoi && !bus_o_atn) eoi_atn_cnt  <= eoi_atn_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Full transfer with a listener that is present but not ready, raises NRFD
  // three cycles after accept and NDAC two cycles after DAV falls. A = accept edge.
  task automatic xfer(input logic [7:0] d, input logic atn, input logic eoi,
                      input logic rel_mid, input string tag);
    logic [7:0] exp_data;
    logic       exp_eoi;
    logic       exp_atn;
    exp_data = ~d;
    exp_eoi  = ~(eoi & ~atn);
    exp_atn  = ~atn;
    bus_i_nrfd = 1'b0;
    bus_i_ndac = 1'b0;
    tick(3);
    check({tag, "_ready_pre"}, 32'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_atn   = atn;
    tx_eoi   = eoi;
    tick(1);                                   // A
    tx_data = ~d;                              // held valid with junk while busy
    tx_atn  = ~atn;
    tx_eoi  = ~eoi;
    check({tag, "_A_ready"}, 32'(tx_ready), 0);
    check({tag, "_A_busy"},  32'(busy), 1);
    check({tag, "_A_data"},  32'(bus_o_data), 32'(exp_data));
    check({tag, "_A_eoi"},   32'(bus_o_eoi), 32'(exp_eoi));
    check({tag, "_A_atn"},   32'(bus_o_atn), 32'(exp_atn));
    check({tag, "_A_dav"},   32'(bus_o_dav), 1);
    tick(3);                                   // A+3
    bus_i_nrfd  = 1'b1;
    atn_release = rel_mid;
    tick(1);                                   // A+4
    atn_release = 1'b0;
    tick(2);                                   // A+6: WAIT_DAC
    check({tag, "_dav_low"},  32'(bus_o_dav), 0);
    check({tag, "_dav_data"}, 32'(bus_o_data), 32'(exp_data));
    check({tag, "_dav_eoi"},  32'(bus_o_eoi), 32'(exp_eoi));
    check({tag, "_dav_atn"},  32'(bus_o_atn), 32'(exp_atn));
    tick(2);                                   // A+8
    bus_i_ndac = 1'b1;
    tick(3);                                   // A+11: RELEASE
    tx_valid = 1'b0;
    check({tag, "_rel_dav"},  32'(bus_o_dav), 1);
    check({tag, "_rel_data"}, 32'(bus_o_data), 32'hFF);
    check({tag, "_rel_eoi"},  32'(bus_o_eoi), 1);
    check({tag, "_rel_done"}, 32'(done), 1);
    check({tag, "_rel_atn"},  32'(bus_o_atn), 32'(exp_atn));
    tick(1);                                   // A+12: IDLE
    check({tag, "_end_done"},  32'(done), 0);
    check({tag, "_end_ready"}, 32'(tx_ready), 1);
    check({tag, "_end_busy"},  32'(busy), 0);
    check({tag, "_end_atn"},   32'(bus_o_atn), 32'(exp_atn));
  endtask

  // WAIT_DAC entered after A+6; its last allowed cycle follows A+21. NDAC
  // driven at A+rise reaches the synchronized level at A+rise+2.
  task automatic dac_race(input int rise, input logic exp_done, input string tag);
    logic exp_err;
    exp_err = ~exp_done;
    bus_i_nrfd = 1'b0;
    bus_i_ndac = 1'b0;
    tick(3);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    tx_atn   = 1'b1;
    tx_eoi   = 1'b0;
    tick(1);                                   // A
    tx_valid = 1'b0;
    tx_atn   = 1'b0;
    check({tag, "_A_atn"}, 32'(bus_o_atn), 0);
    tick(3);                                   // A+3
    bus_i_nrfd = 1'b1;
    tick(rise - 3);
    bus_i_ndac = 1'b1;
    tick(21 - rise);                           // A+21
    check({tag, "_pre_dav"}, 32'(bus_o_dav), 0);
    check({tag, "_pre_err"}, 32'(err_timeout), 0);
    tick(1);                                   // A+22
    check({tag, "_done"},  32'(done), 32'(exp_done));
    check({tag, "_err"},   32'(err_timeout), 32'(exp_err));
    check({tag, "_dav"},   32'(bus_o_dav), 1);
    check({tag, "_data"},  32'(bus_o_data), 32'hFF);
    check({tag, "_eoi"},   32'(bus_o_eoi), 1);
    check({tag, "_atn"},   32'(bus_o_atn), 32'(exp_err));
    check({tag, "_busy"},  32'(busy), 32'(exp_done));
    check({tag, "_ready"}, 32'(tx_ready), 32'(exp_err));
    tick(1);                                   // A+23
    check({tag, "_post_err"},   32'(err_timeout), 0);
    check({tag, "_post_done"},  32'(done), 0);
    check({tag, "_post_ready"}, 32'(tx_ready), 1);
  endtask

  initial begin
    int snap_a, snap_b, snap_c;

    reset_n     = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    tx_atn      = 1'b0;
    tx_eoi      = 1'b0;
    atn_release = 1'b0;
    bus_i_nrfd  = 1'b1;
    bus_i_ndac  = 1'b1;

    // Reset state
    #12;
    check("rst_ready", 32'(tx_ready), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_dav",   32'(bus_o_dav), 1);
    check("rst_data",  32'(bus_o_data), 32'hFF);
    check("rst_eoi",   32'(bus_o_eoi), 1);
    check("rst_atn",   32'(bus_o_atn), 1);
    check("rst_done",  32'(done), 0);
    check("rst_nodev", 32'(err_nodev), 0);
    check("rst_to",    32'(err_timeout), 0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    check("rst_ready_hold", 32'(tx_ready), 0);
    tick(1);
    check("rst_ready_up", 32'(tx_ready), 1);

    // Normal byte 8'h41 with EOI
    snap_a = dav_low_cnt;
    snap_b = done_cnt;
    xfer(8'h41, 1'b0, 1'b1, 1'b0, "b41");
    check("b41_dav_cycles", 32'(dav_low_cnt - snap_a), 5);
    check("b41_one_done",   32'(done_cnt - snap_b), 1);

    // No listeners: both lines released
    snap_a = dav_low_cnt;
    tick(2);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    tx_atn   = 1'b1;
    tx_eoi   = 1'b1;
    tick(1);                                   // A
    tx_valid = 1'b0;
    tx_atn   = 1'b0;
    tx_eoi   = 1'b0;
    check("nodev_A_atn",  32'(bus_o_atn), 0);
    check("nodev_A_eoi",  32'(bus_o_eoi), 1);
    check("nodev_A_data", 32'(bus_o_data), 32'hC3);
    tick(4);                                   // A+4: CHECK
    check("nodev_chk_err",  32'(err_nodev), 0);
    check("nodev_chk_busy", 32'(busy), 1);
    tick(1);                                   // A+5
    check("nodev_err",   32'(err_nodev), 1);
    check("nodev_atn",   32'(bus_o_atn), 1);
    check("nodev_data",  32'(bus_o_data), 32'hFF);
    check("nodev_eoi",   32'(bus_o_eoi), 1);
    check("nodev_busy",  32'(busy), 0);
    check("nodev_ready", 32'(tx_ready), 1);
    tick(1);
    check("nodev_pulse_end", 32'(err_nodev), 0);
    check("nodev_no_dav",    32'(dav_low_cnt - snap_a), 0);

    // Command sequence under held ATN, then a data byte
    snap_c = eoi_atn_cnt;
    xfer(8'h28, 1'b1, 1'b0, 1'b0, "cmd28");
    snap_a = atn_high_cnt;
    xfer(8'h60, 1'b1, 1'b1, 1'b0, "cmd60");
    check("atn_held_low", 32'(atn_high_cnt - snap_a), 0);
    xfer(8'h55, 1'b0, 1'b1, 1'b0, "dat55");
    check("no_eoi_under_atn", 32'(eoi_atn_cnt - snap_c), 0);

    // NDAC one cycle too late -> timeout; exactly on the last cycle -> done
    dac_race(20, 1'b0, "to_late");
    dac_race(19, 1'b1, "to_tie");

    // Reset during WAIT_DAC
    bus_i_nrfd = 1'b0;
    bus_i_ndac = 1'b0;
    tick(3);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tx_atn   = 1'b1;
    tx_eoi   = 1'b0;
    tick(1);                                   // A
    tx_valid = 1'b0;
    tx_atn   = 1'b0;
    tick(3);
    bus_i_nrfd = 1'b1;
    tick(5);                                   // A+8
    check("mid_dav_low", 32'(bus_o_dav), 0);
    snap_a = done_cnt + nodev_cnt + to_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_dav",   32'(bus_o_dav), 1);
    check("mid_rst_data",  32'(bus_o_data), 32'hFF);
    check("mid_rst_eoi",   32'(bus_o_eoi), 1);
    check("mid_rst_atn",   32'(bus_o_atn), 1);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_ready", 32'(tx_ready), 0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    tick(1);
    check("mid_rst_ready_up", 32'(tx_ready), 1);
    check("mid_rst_no_pulse", 32'(done_cnt + nodev_cnt + to_cnt - snap_a), 0);
    xfer(8'hA5, 1'b0, 1'b0, 1'b0, "post_rst");

    // atn_release ignored while busy, honoured in IDLE
    xfer(8'h3F, 1'b1, 1'b0, 1'b1, "atnrel");
    atn_release = 1'b1;
    tick(1);
    atn_release = 1'b0;
    check("atnrel_idle_atn", 32'(bus_o_atn), 1);

    tick(2);
    check("total_done",  32'(done_cnt), 7);
    check("total_nodev", 32'(nodev_cnt), 1);
    check("total_to",    32'(to_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ieee_src_handshake.md
IEEE_SRC_HANDSHAKE -- requirements
Module: ieee_src_handshake

Interface
REQ-001 SHALL have parameter SETTLE, default 16: clk_sys cycles data/EOI/ATN are driven before the listener check; legal 2..255.
REQ-002 SHALL have parameter TIMEOUT, default 65536: clk_sys cycles allowed in each wait state before abort; legal 4..2^24.
REQ-003 clk_sys  in  1  sole clock, all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 tx_valid  in  1  byte offered.
REQ-006 tx_ready  out  1  byte accepted when tx_valid&tx_ready.
REQ-007 tx_data  in  8  byte value, true polarity.
REQ-008 tx_atn  in  1  byte is a command (sent under ATN).
REQ-009 tx_eoi  in  1  last byte (EOI with DAV); ignored when tx_atn=1.
REQ-010 atn_release  in  1  pulse; drops held ATN while idle.
REQ-011 bus_i_nrfd, bus_i_ndac  in  1 each  wired-AND bus levels, 1=high/released, asynchronous.
REQ-012 bus_o_dav, bus_o_eoi, bus_o_atn  out  1 each  1=released, 0=asserted.
REQ-013 bus_o_data  out  8  bus levels, 0=asserted; 8'hFF when released.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done, err_nodev, err_timeout  out  1 each  single-cycle status pulses.

Function
REQ-016 bus_i_nrfd/bus_i_ndac SHALL pass a 2-flop synchronizer (reset value 1); all decisions use synchronized values.
REQ-017 States: IDLE, SETUP, CHECK, WAIT_RFD, WAIT_DAC, RELEASE.
REQ-018 tx_ready SHALL be 1 only in IDLE; acceptance latches tx_data, tx_atn, tx_eoi&~tx_atn and enters SETUP next cycle.
REQ-019 Held ATN flag: set on accepting a byte with tx_atn=1; cleared on accepting a byte with tx_atn=0, on atn_release in IDLE, on any error; bus_o_atn=~flag, updated the cycle after acceptance.
REQ-020 From the cycle after acceptance until RELEASE, bus_o_data=~latched data and bus_o_eoi=~latched eoi.
REQ-021 SETUP SHALL last exactly SETTLE cycles, then CHECK.
REQ-022 CHECK (one cycle): synchronized NRFD=1 and NDAC=1 -> pulse err_nodev, release data/EOI/ATN, IDLE; else WAIT_RFD.
REQ-023 WAIT_RFD: on synchronized NRFD=1 assert bus_o_dav=0 next cycle and enter WAIT_DAC.
REQ-024 WAIT_DAC: on synchronized NDAC=1 enter RELEASE.
REQ-025 RELEASE (one cycle): bus_o_dav=1, bus_o_data=8'hFF, bus_o_eoi=1 simultaneously; pulse done; ATN per flag; next IDLE.
REQ-026 Timeout counter SHALL clear on entry to WAIT_RFD and WAIT_DAC and increment each cycle there; reaching TIMEOUT-1 without the awaited condition -> pulse err_timeout, release DAV/data/EOI/ATN, IDLE.
REQ-027 Awaited condition and timeout in the same cycle: condition wins.
REQ-028 Exactly one of done/err_nodev/err_timeout SHALL pulse per accepted byte.
REQ-029 tx_* changes while busy SHALL have no effect; atn_release outside IDLE SHALL be ignored.
REQ-030 Minimum accept-to-done latency with bus already ready: SETTLE+4 cycles.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, ATN flag 0, all bus_o_* released (1 / 8'hFF), tx_ready=0 while reset_n=0 and 1 from the first cycle after deassertion, busy/done/err_* 0, synchronizers to 1.
REQ-032 Reset mid-transfer SHALL release DAV without a done pulse.

Verification
REQ-033 SETTLE=4, listener model NDAC=0, NRFD 0->1 after 3 cycles, NDAC 0->1 two cycles after DAV low; send 8'h41 eoi=1 -> bus_o_data=8'hBE, eoi=0 until RELEASE, one done, DAV low exactly while NDAC synced low.
REQ-034 Send 8'h28 atn=1 then 8'h60 atn=1 then 8'h55 atn=0 -> ATN low continuously across first two bytes, high after third accept; EOI never asserted under ATN.
REQ-035 No listeners (NRFD=NDAC=1) -> err_nodev at accept+SETTLE+2, no DAV assertion, ATN released.
REQ-036 TIMEOUT=16, listener never raises NDAC after DAV -> err_timeout 16 cycles after WAIT_DAC entry, DAV/data released, tx_ready=1 next cycle.
REQ-037 reset_n pulsed low during WAIT_DAC -> all bus_o_* released asynchronously, no done/err pulse; following byte completes normally.
REQ-038 atn_release asserted during transfer, then again in IDLE -> ignored first, ATN high the cycle after second.
